// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port RAM with byte enables, selectable read-during-write policy,
// optional output register and post-reset zero fill. Lane parity is built when RAM_SDP_PARITY_EN is defined.
module ram_sdp_be #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 7,
  parameter int BYTE_W       = 8,
  parameter int RDW_MODE     = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [DATA_W/BYTE_W-1:0] wr_be_i,
  input  logic                     wr_par_inv_i,
  input  logic                     rd_en_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     busy_o,
  output logic                     parity_err_o
);

  // state   | meaning
  // S_CLEAR | zero-filling the array at clr_addr_q, requests ignored
  // S_READY | normal read/write operation

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic                clearing;
  logic                wr_acc;
  logic                rd_acc;

  logic                mw_en;
  logic [ADDR_W-1:0]   mw_addr;
  logic [DATA_W-1:0]   mw_data;
  logic [NB-1:0]       mw_be;

  logic [NB-1:0][BYTE_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   byp_word;
  logic                same_addr;
  logic [DATA_W-1:0]   rd1_data_d;
  logic [DATA_W-1:0]   rd1_data_q;
  logic                rd1_valid_q;
  logic                rd1_perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
      clr_addr_q <= '0;
    end else if (state_q == S_CLEAR) begin
      clr_addr_q <= clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_ADDR) state_q <= S_READY;
    end
  end

  assign busy_o   = rst | (state_q == S_CLEAR);
  assign clearing = (state_q == S_CLEAR) & ~rst;
  assign wr_acc   = wr_en_i & ~busy_o;
  assign rd_acc   = rd_en_i & ~busy_o;

  // The clear sequencer and the user write share the single write port.
  always_comb begin
    mw_en   = clearing | wr_acc;
    mw_addr = clearing ? clr_addr_q : wr_addr_i;
    mw_data = clearing ? '0 : wr_data_i;
    mw_be   = clearing ? '1 : wr_be_i;
  end

  always_ff @(posedge clk) begin
    if (mw_en) begin
      for (int i = 0; i < NB; i++) begin
        if (mw_be[i]) mem_q[mw_addr][i] <= mw_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    rd_word   = mem_q[rd_addr_i];
    byp_word  = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (wr_be_i[i]) byp_word[i*BYTE_W +: BYTE_W] = wr_data_i[i*BYTE_W +: BYTE_W];
    end
    same_addr  = wr_acc & (wr_addr_i == rd_addr_i);
    rd1_data_d = ((RDW_MODE != 0) && same_addr) ? byp_word : rd_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_valid_q <= 1'b0;
      rd1_data_q  <= '0;
    end else begin
      rd1_valid_q <= rd_acc;
      if (rd_acc) rd1_data_q <= rd1_data_d;
    end
  end

`ifdef RAM_SDP_PARITY_EN
  function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) p[i] = ^d[i*BYTE_W +: BYTE_W];
    return p;
  endfunction

  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] mw_par;
  logic [NB-1:0] wr_par_calc;
  logic [NB-1:0] rd_par_word;
  logic [NB-1:0] rd1_par_d;
  logic [NB-1:0] rd1_par_q;
  logic [NB-1:0] rd1_par_calc;

  // The inversion is a fault-injection hook and never applies to clear writes.
  assign mw_par      = lane_par(mw_data) ^ {NB{wr_par_inv_i & ~clearing}};
  assign wr_par_calc = lane_par(wr_data_i);

  always_ff @(posedge clk) begin
    if (mw_en) begin
      for (int i = 0; i < NB; i++) begin
        if (mw_be[i]) par_q[mw_addr][i] <= mw_par[i];
      end
    end
  end

  always_comb begin
    rd_par_word = par_q[rd_addr_i];
    rd1_par_d   = rd_par_word;
    if ((RDW_MODE != 0) && same_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be_i[i]) rd1_par_d[i] = wr_par_calc[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_par_q <= '0;
    end else if (rd_acc) begin
      rd1_par_q <= rd1_par_d;
    end
  end

  assign rd1_par_calc = lane_par(rd1_data_q);
  assign rd1_perr     = rd1_valid_q & (|(rd1_par_calc ^ rd1_par_q));
`else
  logic unused_par_inv;
  assign unused_par_inv = wr_par_inv_i;
  assign rd1_perr       = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              rd2_valid_q;
      logic              rd2_perr_q;
      logic [DATA_W-1:0] rd2_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd2_valid_q <= 1'b0;
          rd2_perr_q  <= 1'b0;
          rd2_data_q  <= '0;
        end else begin
          rd2_valid_q <= rd1_valid_q;
          rd2_perr_q  <= rd1_perr;
          if (rd1_valid_q) rd2_data_q <= rd1_data_q;
        end
      end

      assign rd_data_o    = rd2_data_q;
      assign rd_valid_o   = rd2_valid_q;
      assign parity_err_o = rd2_perr_q;
    end else begin : g_out_comb
      assign rd_data_o    = rd1_data_q;
      assign rd_valid_o   = rd1_valid_q;
      assign parity_err_o = rd1_perr;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances (old-data/latency 1 and new-data/latency 2) driven
// in lockstep and compared against an array-based reference model.
module tb_ram_sdp_be;

`ifdef RAM_SDP_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_par_inv;
  logic        rd_en;
  logic [6:0]  rd_addr;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        busy0, busy1;
  logic        parity_err0, parity_err1;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [31:0] mem_m [128];
  logic [3:0]  bad_m [128];
  int          clr_left;
  logic        b_exp;
  logic        e0_v, e0_p, s1_v, s1_p, e1_v, e1_p;
  logic [31:0] e0_d, s1_d, e1_d;

  ram_sdp_be u_dut0 (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .wr_par_inv_i(wr_par_inv), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .busy_o(busy0), .parity_err_o(parity_err0)
  );

  ram_sdp_be #(.RDW_MODE(1), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .wr_par_inv_i(wr_par_inv), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .busy_o(busy1), .parity_err_o(parity_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of requests, advance one clock, update the model.
  task automatic step(input logic r, input logic we, input logic [6:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic pi, input logic re, input logic [6:0] ra);
    logic        bsy, aw, ar, pi_eff, same;
    logic [31:0] old_w, mrg;
    logic [3:0]  old_b, st_b, byp_b;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    wr_par_inv = pi; rd_en = re; rd_addr = ra;
    bsy    = r || (clr_left > 0);
    aw     = we && !bsy;
    ar     = re && !bsy;
    pi_eff = pi & PAR_ON;
    old_w  = mem_m[ra];
    old_b  = bad_m[ra];
    mrg    = mem_m[wa];
    st_b   = bad_m[wa];
    byp_b  = bad_m[wa];
    for (int l = 0; l < 4; l++) begin
      if (be[l]) begin
        mrg[l*8 +: 8] = wd[l*8 +: 8];
        st_b[l]       = pi_eff;
        byp_b[l]      = 1'b0;
      end
    end
    same = aw && (wa == ra);
    @(posedge clk);
    #1;
    if (r) begin
      e0_v = 0; e0_p = 0; e0_d = '0;
      s1_v = 0; s1_p = 0; s1_d = '0;
      e1_v = 0; e1_p = 0; e1_d = '0;
      clr_left = 128;
    end else begin
      e1_v = s1_v;
      e1_p = s1_v && s1_p;
      if (s1_v) e1_d = s1_d;
      s1_v = ar;
      if (ar) begin
        s1_d = same ? mrg : old_w;
        s1_p = same ? (|byp_b) : (|old_b);
      end
      e0_v = ar;
      e0_p = ar && (|old_b);
      if (ar) e0_d = old_w;
      if (clr_left > 0) begin
        mem_m[128 - clr_left] = '0;
        bad_m[128 - clr_left] = '0;
        clr_left--;
      end else if (aw) begin
        mem_m[wa] = mrg;
        bad_m[wa] = st_b;
      end
    end
    b_exp = r || (clr_left > 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 7'd0, 32'd0, 4'd0, 0, 0, 7'd0);
  endtask

  task automatic test_reset();
    int n;
    repeat (3) step(1, 0, 7'd0, 32'd0, 4'd0, 0, 0, 7'd0);
    total++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 ||
        rd_data0 !== 32'd0 || rd_data1 !== 32'd0 || parity_err0 !== 1'b0 || parity_err1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got busy=%b%b v=%b%b d0=%h d1=%h p=%b%b exp busy=11 v=00 d=0 p=00",
               busy0, busy1, rd_valid0, rd_valid1, rd_data0, rd_data1, parity_err0, parity_err1);
    end
    n = 0;
    do begin
      idle(1);
      n++;
    end while (busy0 && n < 300);
    total++;
    if (n !== 128 || busy1 !== 1'b0 || b_exp !== 1'b0) begin
      bad++;
      $display("FAIL clear_length got cycles=%0d busy1=%b exp cycles=128 busy1=0", n, busy1);
    end
    step(0, 0, 7'd0, 32'd0, 4'd0, 0, 1, 7'h7F);
    total++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0000_0000) begin
      bad++;
      $display("FAIL clear_read0 got v=%b d=%h exp v=1 d=00000000", rd_valid0, rd_data0);
    end
    idle(1);
    total++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0000_0000 || rd_valid0 !== 1'b0) begin
      bad++;
      $display("FAIL clear_read1 got v1=%b d1=%h v0=%b exp v1=1 d1=00000000 v0=0", rd_valid1, rd_data1, rd_valid0);
    end
  endtask

  task automatic test_busy_mid_clear();
    int   n;
    logic saw_valid;
    saw_valid = 1'b0;
    step(1, 1, 7'd3, 32'h1234_5678, 4'hF, 0, 1, 7'd3);
    for (int i = 0; i < 50; i++) begin
      step(0, 1, 7'(i % 16), $urandom, 4'hF, 0, 1, 7'(i % 16));
      saw_valid = saw_valid | rd_valid0 | rd_valid1;
    end
    step(1, 1, 7'd4, 32'hCAFE_F00D, 4'hF, 0, 1, 7'd4);
    saw_valid = saw_valid | rd_valid0 | rd_valid1;
    n = 0;
    do begin
      step(0, (n >= 40), 7'(n % 16), $urandom | 32'h1, 4'hF, 0, 1, 7'(n % 16));
      saw_valid = saw_valid | rd_valid0 | rd_valid1;
      n++;
    end while (busy0 && n < 300);
    total++;
    if (n !== 128) begin
      bad++;
      $display("FAIL restart_length got cycles=%0d exp cycles=128", n);
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_read_dropped got rd_valid seen=%b exp 0", saw_valid);
    end
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 7'd0, 32'd0, 4'd0, 0, 1, 7'(a));
      total++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== 32'd0) begin
        bad++;
        $display("FAIL busy_write_dropped addr=%0d got v=%b d=%h exp v=1 d=00000000", a, rd_valid0, rd_data0);
      end
    end
    idle(1);
  endtask

  task automatic test_byte_enables();
    step(0, 1, 7'd5, 32'h1122_3344, 4'b1111, 0, 0, 7'd0);
    step(0, 1, 7'd5, 32'hAABB_CCDD, 4'b0101, 0, 0, 7'd0);
    step(0, 0, 7'd0, 32'd0, 4'd0, 0, 1, 7'd5);
    total++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL byte_en0 got v=%b d=%h exp v=1 d=11bb33dd", rd_valid0, rd_data0);
    end
    step(0, 1, 7'd5, 32'hFFFF_FFFF, 4'b0000, 0, 0, 7'd0);
    total++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL byte_en1 got v=%b d=%h exp v=1 d=11bb33dd", rd_valid1, rd_data1);
    end
    step(0, 0, 7'd0, 32'd0, 4'd0, 0, 1, 7'd5);
    total++;
    if (rd_data0 !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL be_zero_noop got d=%h exp d=11bb33dd", rd_data0);
    end
    idle(1);
  endtask

  task automatic test_rdw();
    step(0, 1, 7'd9, 32'hDEAD_BEEF, 4'b1111, 0, 1, 7'd9);
    total++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0000_0000) begin
      bad++;
      $display("FAIL rdw_old got v=%b d=%h exp v=1 d=00000000", rd_valid0, rd_data0);
    end
    idle(1);
    total++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rdw_new got v=%b d=%h exp v=1 d=deadbeef", rd_valid1, rd_data1);
    end
  endtask

  task automatic test_pipeline();
    logic [6:0]  ev0, ev1;
    logic [31:0] ed0 [7];
    logic [31:0] ed1 [7];
    logic        ra_en [7];
    logic [6:0]  ra    [7];
    ed0 = '{32'hA1, 32'hA2, 32'hA3, 32'hA3, 32'hA1, 32'hA1, 32'hA1};
    ed1 = '{32'h0,  32'hA1, 32'hA2, 32'hA3, 32'hA3, 32'hA1, 32'hA1};
    ra_en = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ra    = '{7'd1, 7'd2, 7'd3, 7'd0, 7'd1, 7'd0, 7'd0};
    ev0 = 7'b0010111;
    ev1 = 7'b0101110;
    step(0, 1, 7'd1, 32'hA1, 4'hF, 0, 0, 7'd0);
    step(0, 1, 7'd2, 32'hA2, 4'hF, 0, 0, 7'd0);
    step(0, 1, 7'd3, 32'hA3, 4'hF, 0, 0, 7'd0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 7'd0, 32'd0, 4'd0, 0, ra_en[i], ra[i]);
      total++;
      if (rd_valid0 !== ev0[i] || rd_data0 !== ed0[i]) begin
        bad++;
        $display("FAIL pipe0 cyc=%0d got v=%b d=%h exp v=%b d=%h", i + 1, rd_valid0, rd_data0, ev0[i], ed0[i]);
      end
      if (i > 0) begin
        total++;
        if (rd_valid1 !== ev1[i] || rd_data1 !== ed1[i]) begin
          bad++;
          $display("FAIL pipe1 cyc=%0d got v=%b d=%h exp v=%b d=%h", i + 1, rd_valid1, rd_data1, ev1[i], ed1[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic        r, we, re, pi;
    logic [6:0]  wa, ra;
    logic [31:0] wd;
    logic [3:0]  be;
    for (int n = 0; n < 400; n++) begin
      r  = (n == 150);
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 7'($urandom_range(0, 15));
      ra = 7'($urandom_range(0, 15));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      pi = ($urandom_range(0, 3) == 0);
      step(r, we, wa, wd, be, pi, re, ra);
      total++;
      if (rd_valid0 !== e0_v || rd_data0 !== e0_d || parity_err0 !== e0_p || busy0 !== b_exp) begin
        bad++;
        $display("FAIL rand0 n=%0d got v=%b d=%h p=%b b=%b exp v=%b d=%h p=%b b=%b",
                 n, rd_valid0, rd_data0, parity_err0, busy0, e0_v, e0_d, e0_p, b_exp);
      end
      total++;
      if (rd_valid1 !== e1_v || rd_data1 !== e1_d || parity_err1 !== e1_p || busy1 !== b_exp) begin
        bad++;
        $display("FAIL rand1 n=%0d got v=%b d=%h p=%b b=%b exp v=%b d=%h p=%b b=%b",
                 n, rd_valid1, rd_data1, parity_err1, busy1, e1_v, e1_d, e1_p, b_exp);
      end
    end
    idle(2);
  endtask

`ifdef RAM_SDP_PARITY_EN
  task automatic test_parity();
    step(0, 1, 7'd30, 32'h0000_00FF, 4'b0001, 1, 0, 7'd0);
    step(0, 0, 7'd0, 32'd0, 4'd0, 0, 1, 7'd30);
    total++;
    if (rd_valid0 !== 1'b1 || parity_err0 !== 1'b1 || rd_data0[7:0] !== 8'hFF) begin
      bad++;
      $display("FAIL parity_inv0 got v=%b p=%b d=%h exp v=1 p=1 d[7:0]=ff", rd_valid0, parity_err0, rd_data0);
    end
    idle(1);
    total++;
    if (rd_valid1 !== 1'b1 || parity_err1 !== 1'b1) begin
      bad++;
      $display("FAIL parity_inv1 got v=%b p=%b exp v=1 p=1", rd_valid1, parity_err1);
    end
    step(0, 1, 7'd30, 32'h0000_00FF, 4'b0001, 0, 0, 7'd0);
    step(0, 0, 7'd0, 32'd0, 4'd0, 0, 1, 7'd30);
    total++;
    if (rd_valid0 !== 1'b1 || parity_err0 !== 1'b0) begin
      bad++;
      $display("FAIL parity_ok0 got v=%b p=%b exp v=1 p=0", rd_valid0, parity_err0);
    end
    idle(1);
    total++;
    if (rd_valid1 !== 1'b1 || parity_err1 !== 1'b0) begin
      bad++;
      $display("FAIL parity_ok1 got v=%b p=%b exp v=1 p=0", rd_valid1, parity_err1);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    wr_par_inv = 1'b0; rd_en = 1'b0; rd_addr = '0;
    for (int a = 0; a < 128; a++) begin
      mem_m[a] = '0;
      bad_m[a] = '0;
    end
    clr_left = 0; b_exp = 1'b1;
    e0_v = 0; e0_p = 0; e0_d = '0; s1_v = 0; s1_p = 0; s1_d = '0; e1_v = 0; e1_p = 0; e1_d = '0;
    test_reset();
    test_busy_mid_clear();
    test_byte_enables();
    test_rdw();
    test_pipeline();
`ifdef RAM_SDP_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port synchronous RAM with one write port and one read port.
- Supports per-byte write enables, a selectable read-during-write policy, an optional output pipeline stage and a post-reset clear sequencer.
- Serves as the general-purpose on-chip buffer for datapath blocks.
- Replaces the fixed 8x128 single-port RAM; width, depth and latency are set per instance.

Parameters:
- DATA_W, 32: data width in bits; must be a multiple of BYTE_W.
- ADDR_W, 7: address width; DEPTH = 2**ADDR_W words.
- BYTE_W, 8: byte-lane width; NB = DATA_W/BYTE_W lanes.
- RDW_MODE, 0: same-address read-during-write policy. 0 = old data returned; 1 = new (merged) data returned.
- OUT_REG, 0: 1 adds an output register stage, so read latency = 1 + OUT_REG.
- CLEAR_ON_RST, 1: 1 zero-fills the whole array after reset.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: reset; synchronous, active-high.
- wr_en, input, 1: write request.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, DATA_W: write data.
- wr_be, input, NB: byte enables; bit i selects lane [i*BYTE_W +: BYTE_W].
- wr_par_inv, input, 1: test-only; inverts stored parity (used only with PARITY_EN).
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_W: read address.
- rd_data, output, DATA_W: read data.
- rd_valid, output, 1: rd_data valid for this cycle.
- busy, output, 1: clear sequence in progress; requests are ignored.
- parity_err, output, 1: parity mismatch on the current read; aligned with rd_valid.

Behaviour:
- Reset values (rst=1 at an edge):
  - rd_data=0, rd_valid=0, parity_err=0; all pipeline stages cleared.
  - Array contents are not touched by rst itself.
- State machine: states CLEAR and READY.
  - rst forces CLEAR with clr_addr=0 when CLEAR_ON_RST=1; otherwise rst forces READY.
  - In CLEAR, each cycle with rst=0 writes all-zero data (and correct parity) to clr_addr, then increments clr_addr.
  - After writing DEPTH-1, the FSM moves to READY. CLEAR therefore lasts exactly DEPTH cycles after rst deasserts.
  - busy=1 during rst and throughout CLEAR; busy=0 in READY. With CLEAR_ON_RST=0, busy is 1 only while rst=1.
  - rst asserted mid-clear restarts the clear at address 0.
- Requests while busy=1:
  - wr_en is dropped with no array change.
  - rd_en is dropped and produces no rd_valid.
- Write path:
  - At an edge with wr_en=1 and busy=0, each lane with wr_be[i]=1 is updated from wr_data; other lanes keep their value.
  - wr_be all zero is a no-op.
- Read path:
  - At an edge with rd_en=1 and busy=0, the array is read at rd_addr.
  - rd_data and rd_valid appear 1+OUT_REG cycles later; rd_valid pulses for one cycle per accepted read.
  - Back-to-back reads at full rate give one result per cycle.
  - rd_data holds its last value when rd_valid=0.
- Simultaneous read and write:
  - Different addresses: the two ports are independent.
  - Same address, RDW_MODE=0: read returns pre-write contents.
  - Same address, RDW_MODE=1: read returns the merged word (enabled lanes from wr_data, the rest old).
- Addresses are full-range; there is no out-of-range case.

Optional Feature:
- Macro: RAM_SDP_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written with each enabled lane; wr_par_inv=1 inverts the stored bits of the lanes being written.
  - On read, parity is recomputed per lane. parity_err=1 with rd_valid if any lane mismatches; data is still returned unmodified.
  - Bypass data under RDW_MODE=1 carries its computed parity.
- Undefined: no parity storage; parity_err tied 0; wr_par_inv ignored.

Test Plan:
- Clear sequence: DEPTH=128, CLEAR_ON_RST=1; rst 3 cycles then release -> busy=1 for exactly 128 cycles after release; then read addr 0x7F -> rd_data=0x00000000 with rd_valid after 1+OUT_REG cycles.
- Byte enables: write 0x11223344 be=1111 to addr 5, then 0xAABBCCDD be=0101 -> read addr 5 returns 0x11BB33DD.
- Read-during-write: addr 9 holds 0x0; same-cycle write 0xDEADBEEF be=1111 and read of addr 9 -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0xDEADBEEF.
- Pipeline: OUT_REG=1, reads of addrs 1,2,3 on consecutive cycles -> rd_valid high on cycles 2,3,4 with data in order; an idle cycle between reads gives a gap in rd_valid.
- Busy/reset mid-clear: rst reasserted at clear cycle 50 -> restart; wr_en/rd_en issued during busy -> no array change, no rd_valid.
- Parity (macro on): write 0x000000FF with wr_par_inv=1, be=0001, then read -> parity_err=1 with rd_valid; rewrite with wr_par_inv=0 -> parity_err=0.
